// File: rtl/sign_serial_subtractor.sv
// ---------------------------------------------------------------------------
// sign_serial_subtractor
//
// Multi-cycle two's-complement subtractor for the ALU SUB/CMP path. It
// computes out = a - b - bin as a + ~b + ~bin. Each clock handles one
// STEP-bit slice, starting with the least significant slice, and the carry
// runs from one cycle to the next. After N = WIDTH/STEP slices, the result
// and the adder-style flags are registered and done pulses for one cycle.
//
// Parameters
//   WIDTH  operand/result width in bits
//   STEP   bits processed per clock; WIDTH must be a multiple of STEP
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation in flight)
//   start  request, sampled only while busy = 0
//   a, b   signed minuend / subtrahend, captured on an accepted start
//   bin    borrow-in, captured on an accepted start
//   busy   high while a subtraction is in progress
//   done   one-cycle pulse when out/flags hold a fresh result
//   out    signed difference, held until the next completion
//   of     signed overflow
//   cf     borrow-out (unsigned a < unsigned b + bin)
//   zf     out == 0
//   nf     out[WIDTH-1]
// ---------------------------------------------------------------------------
module sign_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    bin,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] out,
  output logic                    of,
  output logic                    cf,
  output logic                    zf,
  output logic                    nf
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One slice of a + ~b + cin. The result is packed as
  // {carry out of the slice, carry into the slice MSB, slice sum}.
  // The carry into the MSB is needed only for the top slice, where it
  // feeds the signed-overflow flag.
  function automatic logic [STEP+1:0] slice_sub(
    input logic [STEP-1:0] x,
    input logic [STEP-1:0] y,
    input logic            cin
  );
    logic [STEP-1:0] s;
    logic            c;
    logic            c_msb;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < STEP; i++) begin
      c_msb = c;
      s[i]  = x[i] ^ ~y[i] ^ c;
      c     = (x[i] & ~y[i]) | (c & (x[i] ^ ~y[i]));
    end
    return {c, c_msb, s};
  endfunction

  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        a_sh_q, a_sh_d;
  logic [WIDTH-1:0]        b_sh_q, b_sh_d;
  logic                    c_q, c_d;
  logic [WIDTH-1:0]        res_q, res_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    of_q, of_d;
  logic                    cf_q, cf_d;
  logic                    zf_q, zf_d;
  logic                    nf_q, nf_d;
  logic                    done_q, done_d;

  logic [STEP+1:0]         slice_r;
  logic [STEP-1:0]         slice_sum;
  logic                    slice_c_msb;
  logic                    slice_c_out;
  logic [WIDTH-1:0]        res_next;

  // The operand registers shift right one slice per cycle, so the active
  // slice is always in the low STEP bits. The result register shifts right
  // as well, and each new slice enters at the top. After N cycles, slice 0
  // has reached the bottom.
  always_comb begin
    slice_r     = slice_sub(a_sh_q[STEP-1:0], b_sh_q[STEP-1:0], c_q);
    slice_sum   = slice_r[STEP-1:0];
    slice_c_msb = slice_r[STEP];
    slice_c_out = slice_r[STEP+1];
    res_next    = res_q >> STEP;
    res_next[WIDTH-1 -: STEP] = slice_sum;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    c_d     = c_q;
    res_d   = res_q;
    out_d   = out_q;
    of_d    = of_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    nf_d    = nf_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = ~bin;
          res_d   = '0;
        end
      end

      ST_RUN: begin
        a_sh_d = a_sh_q >> STEP;
        b_sh_d = b_sh_q >> STEP;
        c_d    = slice_c_out;
        res_d  = res_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_SLICE) begin
          // At the top slice, the slice carries are the carries at bit WIDTH-1.
          state_d = ST_IDLE;
          cnt_d   = '0;
          out_d   = res_next;
          cf_d    = ~slice_c_out;
          of_d    = slice_c_msb ^ slice_c_out;
          zf_d    = ~|res_next;
          nf_d    = res_next[WIDTH-1];
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      out_q   <= '0;
      of_q    <= 1'b0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      c_q     <= c_d;
      res_q   <= res_d;
      out_q   <= out_d;
      of_q    <= of_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      nf_q    <= nf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign out  = out_q;
  assign of   = of_q;
  assign cf   = cf_q;
  assign zf   = zf_q;
  assign nf   = nf_q;

endmodule

// File: tb/tb_sign_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_sign_serial_subtractor
//
// Self-checking bench for sign_serial_subtractor using the default
// parameters (WIDTH = 32, STEP = 4, N = 8). A plain-arithmetic reference
// model computes the expected values.
// ---------------------------------------------------------------------------
module tb_sign_serial_subtractor;

  localparam int N = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        of;
  logic        cf;
  logic        zf;
  logic        nf;

  int n_cmp;
  int n_bad;

  sign_serial_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .of    (of),
    .cf    (cf),
    .zf    (zf),
    .nf    (nf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The model returns {out, of, cf, zf, nf}, computed from the arithmetic meaning of each result.
  function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mbin);
    logic [31:0] r;
    logic        o;
    logic        c;
    longint      sd;
    r  = ma - mb - {31'b0, mbin};
    c  = ({1'b0, ma} < ({1'b0, mb} + {32'b0, mbin}));
    sd = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
    o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {r, o, c, (r == 32'd0), r[31]};
  endfunction

  // Issue one operation and wait for done. Operands are scrambled every cycle
  // while the operation is busy. The task returns at #1 after the done edge.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic ibin,
                       output int lat);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin
      a = $urandom; b = $urandom; bin = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, out, of, cf, zf, nf} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", {busy, done, out, of, cf, zf, nf});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy/done %b want 00", {busy, done});
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vbin [6];
    logic [35:0] exp_v;
    int          lat;
    va   = '{32'd5, 32'd3, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0};
    vb   = '{32'd3, 32'd5, 32'd7, 32'd1,         32'hFFFF_FFFF, 32'd0};
    vbin = '{1'b0,  1'b0,  1'b0,  1'b0,          1'b0,          1'b1};
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vbin[i], lat);
      exp_v = model(va[i], vb[i], vbin[i]);
      n_cmp++;
      if (lat != N) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, N);
      end
      n_cmp++;
      if ({out, of, cf, zf, nf} !== exp_v) begin
        n_bad++;
        $display("FAIL directed_result[%0d]: got out=%h of%b cf%b zf%b nf%b want out=%h of%b cf%b zf%b nf%b",
                 i, out, of, cf, zf, nf, exp_v[35:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rbin;
    logic [35:0] exp_v;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom);
      if (i % 4 == 1) rb = ra;                     // exercises the zero result
      if (i % 4 == 2) ra = {1'b1, ra[30:0]};       // negative minuend, overflow-prone
      do_op(ra, rb, rbin, lat);
      exp_v = model(ra, rb, rbin);
      n_cmp++;
      if (lat != N || {out, of, cf, zf, nf} !== exp_v) begin
        n_bad++;
        $display("FAIL random[%0d] a=%h b=%h bin=%b: got lat=%0d res=%h want lat=%0d res=%h",
                 i, ra, rb, rbin, lat, {out, of, cf, zf, nf}, N, exp_v);
      end
    end
  endtask

  task automatic test_start_held();
    int lat;
    int extra;
    @(negedge clk);
    a = 32'd100; b = 32'd1; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;                                  // dropped before the done-cycle edge
    n_cmp++;
    if (lat != N || out !== 32'd99) begin
      n_bad++;
      $display("FAIL start_held: got lat=%0d out=%0d want lat=%0d out=99", lat, out, N);
    end
    extra = 0;
    repeat (2 * N) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL start_held_single_accept: got %0d extra busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp1;
    logic [35:0] exp2;
    int          lat;
    int          gap;
    logic        held;
    exp1 = model(32'd1000, 32'd1, 1'b1);
    exp2 = model(32'h8000_0000, 32'h0000_0001, 1'b0);
    do_op(32'd1000, 32'd1, 1'b1, lat);
    n_cmp++;
    if ({out, of, cf, zf, nf} !== exp1) begin
      n_bad++;
      $display("FAIL b2b_first: got %h want %h", {out, of, cf, zf, nf}, exp1);
    end
    // The next start is raised during the done cycle.
    a = 32'h8000_0000; b = 32'h0000_0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    gap  = 1;
    held = 1'b1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy);
    end
    while (!done && gap < 50) begin
      if ({out, of, cf, zf, nf} !== exp1) held = 1'b0;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      gap++;
    end
    n_cmp++;
    if (held !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_hold: got out changed during second op want held at %h", exp1[35:4]);
    end
    n_cmp++;
    if (gap != N + 1) begin
      n_bad++;
      $display("FAIL b2b_gap: got %0d want %0d", gap, N + 1);
    end
    n_cmp++;
    if ({out, of, cf, zf, nf} !== exp2) begin
      n_bad++;
      $display("FAIL b2b_second: got %h want %h", {out, of, cf, zf, nf}, exp2);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray;
    do_op(32'd5, 32'd3, 1'b0, lat);                // leaves a nonzero result behind
    @(negedge clk);
    a = 32'd9; b = 32'd1; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, out, of, cf, zf, nf} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_mid_clear: got %h want 0", {busy, done, out, of, cf, zf, nf});
    end
    @(negedge clk); rst_n = 1'b1;
    stray = 0;
    repeat (2 * N) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_done: got %0d busy/done cycles want 0", stray);
    end
    do_op(32'd10, 32'd4, 1'b0, lat);
    n_cmp++;
    if (lat != N || out !== 32'd6 || {of, cf, zf, nf} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_mid_recover: got lat=%0d out=%0d flags=%b want lat=%0d out=6 flags=0000",
               lat, out, {of, cf, zf, nf}, N);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sign_serial_subtractor.md
Name: sign_serial_subtractor

Overview:
- Multi-cycle signed subtractor. Computes out = a - b - bin on WIDTH-bit two's-complement operands, STEP bits per clock, LSB slice first.
- Reports the same flag set as the ALU adder path: of, cf, zf, nf.
- Sits in the ALU's SUB/CMP path where area matters more than latency.
- Uses a start/busy/done handshake toward the ALU control sequencer.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STEP, 4, bits processed per clock. Must divide WIDTH evenly.
- N = WIDTH/STEP is derived, not a parameter. Default N = 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  signed minuend; captured on an accepted start
- b  input  WIDTH  signed subtrahend; captured on an accepted start
- bin  input  1  borrow-in; captured on an accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when the result is valid
- out  output  WIDTH  signed difference; held until the next completion
- of  output  1  signed overflow
- cf  output  1  borrow-out: 1 when unsigned a < unsigned b + bin
- zf  output  1  out == 0
- nf  output  1  out[WIDTH-1]

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, busy=0, done=0, out=0, of=cf=zf=nf=0.
  - Slice counter, operand registers and internal carry are cleared.
  - Reset mid-operation aborts the operation. No done is produced for it.
- Arithmetic:
  - Implemented as a + ~b + ~bin.
  - Internal carry register c is initialised to ~bin on accept.
  - Slice k (bits k*STEP+STEP-1 .. k*STEP) is added in cycle k. The carry is propagated across cycles.
  - Final carry-out C = carry out of bit WIDTH-1. cf = ~C.
  - of = (carry into bit WIDTH-1) XOR C.
  - zf = ~|out. nf = out[WIDTH-1].
- FSM states: IDLE and RUN.
- IDLE:
  - busy=0.
  - start=1 at a rising edge captures a, b, bin, sets counter=0 and goes to RUN.
  - start=0 keeps the FSM in IDLE.
- RUN:
  - busy=1. Each edge processes one slice and increments the counter.
  - On the edge that processes slice N-1: out and the flags are registered, done=1 for exactly the following cycle, state returns to IDLE, busy=0.
- Latency:
  - start accepted at edge t gives done=1 during the cycle after edge t+N.
  - Default: done is high 8 clocks after the accepting edge.
- Back-to-back operation:
  - start is honoured in the cycle done=1, since busy=0 then.
  - Peak throughput is one result per N+1 cycles.
- start while busy=1 is ignored. Operand inputs are don't-care outside the accepting edge.
- out and the flags change only at completion and are stable at all other times, including during the next operation.
- done never asserts without a preceding accepted start.

Test Plan:
- a=5, b=3, bin=0 -> after 8 cycles: done pulse, out=2, of=0, cf=0, zf=0, nf=0.
- a=3, b=5, bin=0 -> out=0xFFFFFFFE (-2), cf=1, nf=1, of=0, zf=0. Then a=7, b=7 -> out=0, zf=1, cf=0.
- a=0x80000000, b=1 -> out=0x7FFFFFFF, of=1, cf=0, nf=0. Also a=0x7FFFFFFF, b=0xFFFFFFFF -> out=0x80000000, of=1, cf=1, nf=1.
- a=0, b=0, bin=1 -> out=0xFFFFFFFF, cf=1, nf=1, of=0. Confirms borrow-in handling.
- Handshake checks:
  - start held high through a whole operation -> exactly one accept.
  - New start asserted in the done cycle -> accepted; its done arrives 9 cycles after the first done.
  - Operand inputs changed while busy -> result unaffected.
- Reset checks:
  - rst_n pulsed low at RUN cycle 4 -> busy=0, done=0, out and all flags 0 immediately, no done afterwards.
  - A following start with a=10, b=4 -> out=6 with normal latency.
